digit_display_controller: RTL and testbench
===========================================

Name: digit_display_controller

Overview:
- Sequences the two 9-digit draw enables (`set9[1]` = left/red, `set9[0]` = right/green) and the press-highlight flag for the circle overlay. All three are driven from debounced btnL/btnR presses.
- Sits between the raw pushbuttons and the character compositor. Its outputs replace the compositor's hard-wired `set9` and its ad-hoc button polling.
- Runs entirely on the 1 kHz clock, so all time parameters are in milliseconds (1 cycle = 1 ms).

Parameters:
- DEBOUNCE_MS, 20, cycles the synchronised button must differ from its debounced level before the level is accepted (min 2).
- BLINK_MS, 250, half-period of the BLINK pattern, in cycles (min 1).
- HOLD_MS, 3000, cycles spent in BOTH_ON with no press before auto-entering BLINK (min 1).
- FLASH_MS, 100, cycles press_flash stays high after a press event (min 1).

Ports:
- clock  input  1  1 kHz clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- btnL  input  1  raw left pushbutton, asynchronous.
- btnR  input  1  raw right pushbutton, asynchronous.
- set9  output  2  digit enables: [1] = left digit, [0] = right digit; registered.
- press_flash  output  1  high while the circle must show the press colour; registered.
- state  output  3  FSM state: IDLE=0, LEFT_ON=1, RIGHT_ON=2, BOTH_ON=3, BLINK=4; registered.

Behaviour:
- Reset (sampled on the clock edge while reset=1):
  - set9=00, press_flash=0, state=IDLE.
  - Sync flops, debounced levels, and all counters cleared.
  - Reset asserted mid-operation overrides every event in that cycle.
- Input synchronisation: each button passes through 2 flops, giving the synchronised signal b_s.
- Debounce, per button, with a counter width of clog2(DEBOUNCE_MS):
  - If b_s equals the debounced level db, the counter is cleared.
  - Otherwise the counter increments. When it equals DEBOUNCE_MS-1 while b_s≠db, db takes b_s and the counter clears.
  - Any glitch back to db before that point clears the counter.
- Press event:
  - A press is the edge at which db goes 0→1. Releases generate no event.
  - Latency: button high sampled from edge N onward → press acts at edge N+DEBOUNCE_MS+1.
  - A button still held when reset deasserts produces a press after debounce.
- FSM transitions occur at the press edge itself (pL = left press, pR = right press, pLR = both pressed on the same edge):
  - IDLE: pL→LEFT_ON, pR→RIGHT_ON.
  - LEFT_ON: pL→IDLE, pR→BOTH_ON.
  - RIGHT_ON: pR→IDLE, pL→BOTH_ON.
  - BOTH_ON: pL→RIGHT_ON, pR→LEFT_ON; hold timeout→BLINK.
  - BLINK: a single press (pL or pR)→BOTH_ON; pLR→IDLE.
  - Any non-BLINK state: pLR→BLINK.
- set9 per state: IDLE=00, LEFT_ON=10, RIGHT_ON=01, BOTH_ON=11. Register set9 together with state, so both change on the same edge.
- Hold timer:
  - Cleared on every entry to BOTH_ON; increments each cycle while in BOTH_ON.
  - Entry at edge E with no further press → BLINK at edge E+HOLD_MS.
  - A press arriving on the same edge as the timeout wins.
- BLINK:
  - On entry, set9=11 and the phase counter is cleared.
  - set9 toggles between 11 and 00 every BLINK_MS cycles (first toggle at entry+BLINK_MS) for as long as the FSM stays in BLINK.
- press_flash:
  - Goes high at the edge of any press event (pL, pR or pLR) and stays high for exactly FLASH_MS cycles.
  - A new press while high reloads the counter to the full FLASH_MS.
- No combinational path exists from any input to any output.

Test Plan (overrides DEBOUNCE_MS=4, BLINK_MS=8, HOLD_MS=32, FLASH_MS=6):
1. Reset, then drive btnL=1 from edge 10 → set9=10 and state=1 after edge 15. press_flash is high for edges 15–20 and low from edge 21. Releasing btnL causes no change.
2. In LEFT_ON, pulse btnL high for 3 cycles (shorter than debounce) → no state change and press_flash stays 0. Then a clean btnR press → set9=11, state=3.
3. In BOTH_ON, entered at edge E, with no presses → state=4 at edge E+32. set9 is 11 until E+39, 00 from E+40, and 11 from E+48.
4. Raise btnL and btnR on the same edge while in RIGHT_ON → both presses land on the same edge → state=4. Repeat the dual press → state=0, set9=00.
5. Assert reset for 1 cycle during BLINK while btnR is held → set9=00, state=0. Six edges after reset deasserts, the held btnR registers as a press → state=2, set9=01.
6. Two presses 3 cycles apart → press_flash stays continuously high until 6 cycles after the second press.

Source files
------------

// File: rtl/digit_display_controller_if.sv
// Button inputs and display-control outputs of the digit display controller.
// Latency: none, wires only.
// Backpressure: none; levels only, no handshake.
interface digit_display_controller_if;
    logic       btnL;
    logic       btnR;
    logic [1:0] set9;
    logic       press_flash;
    logic [2:0] state;

    // Environment side: drives the buttons and observes the display controls.
    modport master (
        output btnL,
        output btnR,
        input  set9,
        input  press_flash,
        input  state
    );

    // Controller side.
    modport slave (
        input  btnL,
        input  btnR,
        output set9,
        output press_flash,
        output state
    );
endinterface

// File: rtl/digit_display_controller.sv
// Debounces btnL/btnR and sequences the two 9-digit enables plus the press-highlight flag.
// Latency: a button is sampled high at edge N; its press acts at edge N+DEBOUNCE_MS+1.
// Backpressure: none; this is free-running on the 1 kHz clock and every output is registered.
module digit_display_controller #(
    parameter int DEBOUNCE_MS = 20,
    parameter int BLINK_MS    = 250,
    parameter int HOLD_MS     = 3000,
    parameter int FLASH_MS    = 100
) (
    input  logic                      clock,
    input  logic                      reset,
    digit_display_controller_if.slave io
);
    localparam int DBW = $clog2(DEBOUNCE_MS);
    localparam int HW  = $clog2(HOLD_MS + 1);
    localparam int BW  = $clog2(BLINK_MS + 1);
    localparam int FW  = $clog2(FLASH_MS + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0]  HOLD_LAST  = HW'(HOLD_MS - 1);
    localparam logic [BW-1:0]  BLINK_LAST = BW'(BLINK_MS - 1);
    localparam logic [FW-1:0]  FLASH_LAST = FW'(FLASH_MS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEFT_ON  = 3'd1,
        RIGHT_ON = 3'd2,
        BOTH_ON  = 3'd3,
        BLINK    = 3'd4
    } state_e;

    // Index 1 is the left button and index 0 the right one, matching set9.
    logic [1:0]     sync1_q;
    logic [1:0]     sync2_q;
    logic [1:0]     db_q;
    logic [DBW-1:0] dbc_q [2];
    logic [1:0]     press;

    state_e         state_q, state_d;
    logic [1:0]     set9_q, set9_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic [BW-1:0]  phase_q, phase_d;
    logic [FW-1:0]  flash_cnt_q, flash_cnt_d;
    logic           flash_q, flash_d;

    logic p_l, p_r, p_lr;

    // Two-flop synchroniser followed by a per-button debounce counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            for (int i = 0; i < 2; i++) dbc_q[i] <= '0;
        end else begin
            sync1_q <= {io.btnL, io.btnR};
            sync2_q <= sync1_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == db_q[i]) begin
                    dbc_q[i] <= '0;
                end else if (dbc_q[i] == DB_LAST) begin
                    db_q[i]  <= sync2_q[i];
                    dbc_q[i] <= '0;
                end else begin
                    dbc_q[i] <= dbc_q[i] + 1'b1;
                end
            end
        end
    end

    // A press is the edge on which the debounced level is about to rise.
    // It is decoded early so the FSM moves on that same edge.
    always_comb begin
        press = '0;
        for (int i = 0; i < 2; i++) begin
            press[i] = sync2_q[i] & ~db_q[i] & (dbc_q[i] == DB_LAST);
        end
    end

    assign p_l  = press[1];
    assign p_r  = press[0];
    assign p_lr = press[1] & press[0];

    // Next state, digit enables, hold/blink timers and the flash counter.
    always_comb begin
        state_d     = state_q;
        set9_d      = set9_q;
        hold_d      = '0;
        phase_d     = phase_q;
        flash_cnt_d = flash_cnt_q;
        flash_d     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if      (p_lr) state_d = BLINK;
                else if (p_l)  state_d = LEFT_ON;
                else if (p_r)  state_d = RIGHT_ON;
            end
            LEFT_ON: begin
                if      (p_lr) state_d = BLINK;
                else if (p_l)  state_d = IDLE;
                else if (p_r)  state_d = BOTH_ON;
            end
            RIGHT_ON: begin
                if      (p_lr) state_d = BLINK;
                else if (p_r)  state_d = IDLE;
                else if (p_l)  state_d = BOTH_ON;
            end
            BOTH_ON: begin
                // Presses are tested before the timeout so they win a tie.
                if      (p_lr)                state_d = BLINK;
                else if (p_l)                 state_d = RIGHT_ON;
                else if (p_r)                 state_d = LEFT_ON;
                else if (hold_q == HOLD_LAST) state_d = BLINK;
            end
            BLINK: begin
                if      (p_lr)       state_d = IDLE;
                else if (p_l || p_r) state_d = BOTH_ON;
            end
            default: state_d = IDLE;
        endcase

        // The hold timer restarts on entry and counts while BOTH_ON persists.
        if (state_d == BOTH_ON && state_q == BOTH_ON) begin
            hold_d = hold_q + 1'b1;
        end

        unique case (state_d)
            IDLE:     set9_d = 2'b00;
            LEFT_ON:  set9_d = 2'b10;
            RIGHT_ON: set9_d = 2'b01;
            BOTH_ON:  set9_d = 2'b11;
            BLINK: begin
                if (state_q != BLINK) begin
                    set9_d  = 2'b11;
                    phase_d = '0;
                end else if (phase_q == BLINK_LAST) begin
                    set9_d  = ~set9_q;
                    phase_d = '0;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            default: set9_d = 2'b00;
        endcase

        // Any press reloads the full flash window, including one that is already running.
        if (p_l || p_r) begin
            flash_cnt_d = FLASH_LAST;
            flash_d     = 1'b1;
        end else if (flash_cnt_q != '0) begin
            flash_cnt_d = flash_cnt_q - 1'b1;
            flash_d     = 1'b1;
        end
    end

    // State and output registers; set9 updates on the same edge as the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            set9_q      <= 2'b00;
            hold_q      <= '0;
            phase_q     <= '0;
            flash_cnt_q <= '0;
            flash_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            set9_q      <= set9_d;
            hold_q      <= hold_d;
            phase_q     <= phase_d;
            flash_cnt_q <= flash_cnt_d;
            flash_q     <= flash_d;
        end
    end

    assign io.set9        = set9_q;
    assign io.press_flash = flash_q;
    assign io.state       = state_q;
endmodule

// File: tb/tb_digit_display_controller.sv
// Bench for digit_display_controller with short time parameters.
// Latency: expectations are keyed to absolute clock-edge numbers.
// Backpressure: none.
module tb_digit_display_controller;
    logic clock;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int         cyc;
        string      tag;
        logic [5:0] st;
    } exp_t;

    exp_t sb [$];

    digit_display_controller_if dif ();

    digit_display_controller #(
        .DEBOUNCE_MS (4),
        .BLINK_MS    (8),
        .HOLD_MS     (32),
        .FLASH_MS    (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .io    (dif)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", tag, cyc, got[5:0], exp[5:0]);
        end
    endtask

    // Expected {set9, press_flash, state} after edge c, kept sorted by edge.
    task automatic exp_at(input int c, input string t, input logic [1:0] s9,
                          input logic fl, input logic [2:0] stt);
        exp_t e;
        int   idx;
        e.cyc = c;
        e.tag = t;
        e.st  = {s9, fl, stt};
        idx   = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].cyc > c) begin
                idx = i;
                break;
            end
        end
        sb.insert(idx, e);
    endtask

    task automatic wait_cyc(input int n);
        while (cyc != n) @(negedge clock);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish by edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        dif.btnL = 1'b0;
        dif.btnR = 1'b0;

        // Scoreboard drain: compare outputs half a cycle after each edge.
        fork
            begin
                exp_t e;
                forever begin
                    @(negedge clock);
                    while (sb.size() > 0 && sb[0].cyc == cyc) begin
                        e = sb.pop_front();
                        chk(e.tag, {26'd0, dif.set9, dif.press_flash, dif.state}, {26'd0, e.st});
                    end
                end
            end
        join_none

        exp_at(2, "reset", 2'b00, 1'b0, 3'd0);
        wait_cyc(2);
        reset = 1'b0;

        // Left press sampled from edge 10, release has no effect.
        exp_at(14, "l_pre",       2'b00, 1'b0, 3'd0);
        exp_at(15, "l_press",     2'b10, 1'b1, 3'd1);
        exp_at(20, "flash_last",  2'b10, 1'b1, 3'd1);
        exp_at(21, "flash_off",   2'b10, 1'b0, 3'd1);
        wait_cyc(9);
        dif.btnL = 1'b1;
        wait_cyc(22);
        dif.btnL = 1'b0;
        exp_at(30, "l_release",   2'b10, 1'b0, 3'd1);

        // Three-cycle glitch is filtered, then a clean right press.
        wait_cyc(31);
        dif.btnL = 1'b1;
        exp_at(37, "glitch_a",    2'b10, 1'b0, 3'd1);
        exp_at(40, "glitch_b",    2'b10, 1'b0, 3'd1);
        wait_cyc(34);
        dif.btnL = 1'b0;
        wait_cyc(44);
        dif.btnR = 1'b1;
        exp_at(49, "r_pre",       2'b10, 1'b0, 3'd1);
        exp_at(50, "r_press",     2'b11, 1'b1, 3'd3);
        exp_at(56, "both_fl_off", 2'b11, 1'b0, 3'd3);
        wait_cyc(52);
        dif.btnR = 1'b0;

        // Hold timeout from entry at edge 50, then blink phases.
        exp_at(81, "hold_pre",    2'b11, 1'b0, 3'd3);
        exp_at(82, "hold_to",     2'b11, 1'b0, 3'd4);
        exp_at(89, "blink_on",    2'b11, 1'b0, 3'd4);
        exp_at(90, "blink_off",   2'b00, 1'b0, 3'd4);
        exp_at(97, "blink_off2",  2'b00, 1'b0, 3'd4);
        exp_at(98, "blink_on2",   2'b11, 1'b0, 3'd4);

        // Single press leaves BLINK, then left press to RIGHT_ON.
        wait_cyc(99);
        dif.btnR = 1'b1;
        exp_at(105, "blink_single", 2'b11, 1'b1, 3'd3);
        wait_cyc(107);
        dif.btnR = 1'b0;
        wait_cyc(109);
        dif.btnL = 1'b1;
        exp_at(112, "both_again",  2'b11, 1'b0, 3'd3);
        exp_at(115, "to_right",    2'b01, 1'b1, 3'd2);
        wait_cyc(117);
        dif.btnL = 1'b0;

        // Dual press into BLINK, then dual press back to IDLE.
        wait_cyc(124);
        dif.btnL = 1'b1;
        dif.btnR = 1'b1;
        exp_at(129, "dual_pre",    2'b01, 1'b0, 3'd2);
        exp_at(130, "dual_blink",  2'b11, 1'b1, 3'd4);
        wait_cyc(132);
        dif.btnL = 1'b0;
        dif.btnR = 1'b0;
        exp_at(137, "dual_hold",   2'b11, 1'b0, 3'd4);
        exp_at(138, "dual_toggle", 2'b00, 1'b0, 3'd4);
        wait_cyc(139);
        dif.btnL = 1'b1;
        dif.btnR = 1'b1;
        exp_at(145, "dual_idle",   2'b00, 1'b1, 3'd0);
        wait_cyc(147);
        dif.btnL = 1'b0;
        dif.btnR = 1'b0;

        // Reset during BLINK with right button held.
        wait_cyc(154);
        dif.btnL = 1'b1;
        dif.btnR = 1'b1;
        exp_at(160, "blink_enter", 2'b11, 1'b1, 3'd4);
        wait_cyc(161);
        dif.btnL = 1'b0;
        wait_cyc(164);
        reset = 1'b1;
        exp_at(165, "mid_reset",   2'b00, 1'b0, 3'd0);
        wait_cyc(165);
        reset = 1'b0;
        exp_at(170, "held_pre",    2'b00, 1'b0, 3'd0);
        exp_at(171, "held_r",      2'b01, 1'b1, 3'd2);

        // Two presses three edges apart keep the flash continuous.
        wait_cyc(172);
        dif.btnR = 1'b0;
        wait_cyc(179);
        dif.btnL = 1'b1;
        exp_at(185, "p1",          2'b11, 1'b1, 3'd3);
        wait_cyc(182);
        dif.btnR = 1'b1;
        exp_at(187, "p1_hold",     2'b11, 1'b1, 3'd3);
        exp_at(188, "p2",          2'b10, 1'b1, 3'd1);
        exp_at(191, "reload",      2'b10, 1'b1, 3'd1);
        exp_at(193, "reload_end",  2'b10, 1'b1, 3'd1);
        exp_at(194, "flash_done",  2'b10, 1'b0, 3'd1);

        wait_cyc(200);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
